// File: rtl/seq_frame_ctrl.sv
// seq_frame_ctrl: frame sequencer around the seq_detect_mealy serial detector.
// A parallel word is taken over a valid/ready handshake and shifted out MSB-first
// into the detector, one bit per clock. Hits are counted, the bit index that
// completed the first hit is remembered, and a per-frame result is returned over a
// second valid/ready handshake. The detector model lives in this file so the block
// is self-contained.

// Mealy detector for the pattern 1101 with overlap. The output is high
// combinationally in the cycle the final '1' sits on din.
module seq_detect_mealy (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic y
);

   typedef enum logic [1:0] {
      S_NONE,
      S_1,
      S_11,
      S_110
   } detState_e;

   detState_e state_q;
   detState_e state_d;

   // Next-state and Mealy output. After a hit, the trailing '1' is reused as the
   // start of the next match, which gives overlapping detection.
   always_comb begin
      state_d = S_NONE;
      y       = 1'b0;
      case (state_q)
         S_NONE:  state_d = din ? S_1 : S_NONE;
         S_1:     state_d = din ? S_11 : S_NONE;
         S_11:    state_d = din ? S_11 : S_110;
         S_110: begin
            if (din) begin
               state_d = S_1;
               y       = 1'b1;
            end else begin
               state_d = S_NONE;
            end
         end
         default: state_d = S_NONE;
      endcase
   end

   // Pattern-progress register. Reset is synchronous and also serves as the
   // per-frame clear from the sequencer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_NONE;
      end else begin
         state_q <= state_d;
      end
   end

endmodule

// Frame sequencer: IDLE -> CLEAR -> SHIFT (WIDTH cycles) -> DONE -> IDLE.
module seq_frame_ctrl #(
   parameter int WIDTH = 20,
   parameter int CNT_W = $clog2(WIDTH + 1),
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             abort,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] out_count,
   output logic             out_hit,
   output logic [IDX_W-1:0] out_first,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      SHIFT,
      DONE
   } state_e;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

   state_e           state_q;
   state_e           state_d;
   logic [WIDTH-1:0] shift_q;
   logic [WIDTH-1:0] shift_d;
   logic [IDX_W-1:0] idx_q;
   logic [IDX_W-1:0] idx_d;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic [IDX_W-1:0] first_q;
   logic [IDX_W-1:0] first_d;
   logic             hitSeen_q;
   logic             hitSeen_d;
   logic             inReady_q;
   logic             outValid_q;
   logic             busy_q;

   logic             detClr;
   logic             detRst;
   logic             detDin;
   logic             detY;

   // Detector hookup. The detector is reset for the single CLEAR cycle so that
   // every frame starts from a clean pattern state and no match can straddle two
   // frames. Outside SHIFT the detector input is held low; its state does not
   // matter there because CLEAR always comes before the next SHIFT.
   assign detClr = (state_q == CLEAR);
   assign detRst = rst | detClr;
   assign detDin = (state_q == SHIFT) & shift_q[WIDTH-1];

   seq_detect_mealy u_det (
      .clk (clk),
      .rst (detRst),
      .din (detDin),
      .y   (detY)
   );

   // Next-state logic for the sequencer and its datapath. Everything holds by
   // default; each state only touches what it owns. An abort outside IDLE
   // overrides whatever transition the state would have taken, including a
   // DONE handshake in the same cycle, which lands in IDLE either way.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      idx_d     = idx_q;
      count_d   = count_q;
      first_d   = first_q;
      hitSeen_d = hitSeen_q;

      case (state_q)
         IDLE: begin
            if (in_valid && inReady_q) begin
               shift_d = in_data;
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            count_d   = '0;
            first_d   = '0;
            hitSeen_d = 1'b0;
            idx_d     = '0;
            state_d   = SHIFT;
         end
         SHIFT: begin
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
            idx_d   = idx_q + IDX_W'(1);
            if (detY) begin
               count_d = count_q + CNT_W'(1);
               if (!hitSeen_q) begin
                  first_d   = idx_q;
                  hitSeen_d = 1'b1;
               end
            end
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (outValid_q && out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (abort && (state_q != IDLE)) begin
         state_d = IDLE;
      end
   end

   // State, datapath and registered handshake/status outputs. The handshake
   // flags are computed from the next state so they line up exactly with the
   // state they describe, without any combinational path from the inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         idx_q      <= '0;
         count_q    <= '0;
         first_q    <= '0;
         hitSeen_q  <= 1'b0;
         inReady_q  <= 1'b1;
         outValid_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         idx_q      <= idx_d;
         count_q    <= count_d;
         first_q    <= first_d;
         hitSeen_q  <= hitSeen_d;
         inReady_q  <= (state_d == IDLE);
         outValid_q <= (state_d == DONE);
         busy_q     <= (state_d != IDLE);
      end
   end

   // Result fields come straight from registers that are frozen in DONE, so they
   // stay stable for as long as the consumer stalls.
   assign in_ready  = inReady_q;
   assign out_valid = outValid_q;
   assign out_count = count_q;
   assign out_hit   = hitSeen_q;
   assign out_first = first_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_seq_frame_ctrl.sv
// tb_seq_frame_ctrl: self-checking bench for seq_frame_ctrl.
// Expected results are pushed to a scoreboard queue when a frame is accepted and
// popped when the DUT presents its result.
module tb_seq_frame_ctrl;

   localparam int WIDTH = 20;
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int IDX_W = $clog2(WIDTH);
   localparam int NVEC  = 8;
   localparam int BOUND = 200;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             abort;
   logic             out_valid;
   logic             out_ready;
   logic [CNT_W-1:0] out_count;
   logic             out_hit;
   logic [IDX_W-1:0] out_first;
   logic             busy;

   typedef struct {
      logic [WIDTH-1:0] data;
      int               count;
      int               first;
   } vec_t;

   typedef struct {
      int count;
      int first;
      int hit;
   } exp_t;

   exp_t expQ[$];
   vec_t vecs[NVEC];
   int   accCyc[NVEC];
   int   vecCount = 0;
   int   errCount = 0;
   int   cycNum = 0;

   seq_frame_ctrl #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W),
      .IDX_W (IDX_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .abort     (abort),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_count (out_count),
      .out_hit   (out_hit),
      .out_first (out_first),
      .busy      (busy)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Free-running cycle counter used to measure accept spacing
   always @(posedge clk) cycNum <= cycNum + 1;

   // Hard stop in case something wedges outside the bounded waits
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vecCount++;
      if (actual !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic expire(input string name);
      vecCount++;
      errCount++;
      $display("[TB] FAIL %s: got timeout, expected DUT response", name);
   endtask

   // Sliding-window reference: a hit completes at index k when bits k-3..k read 1101
   function automatic exp_t refModel(input logic [WIDTH-1:0] d);
      exp_t       r;
      logic [3:0] win;
      r   = '{0, 0, 0};
      win = 4'b0000;
      for (int k = 0; k < WIDTH; k++) begin
         win = {win[2:0], d[WIDTH-1-k]};
         if (k >= 3 && win == 4'b1101) begin
            if (r.count == 0) r.first = k;
            r.count++;
         end
      end
      r.hit = (r.count != 0) ? 1 : 0;
      return r;
   endfunction

   // Present a frame, wait (bounded) for in_ready, and let it be accepted on the
   // next edge. Returns at #1 after the accept edge with in_valid dropped.
   task automatic applyStimulus(input logic [WIDTH-1:0] d, input bit track, input exp_t e,
                                output int acceptCyc);
      int n;
      n         = 0;
      acceptCyc = -1;
      in_data   = d;
      in_valid  = 1'b1;
      while (!in_ready && n < BOUND) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!in_ready) begin
         expire("accept");
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      acceptCyc = cycNum;
      if (track) expQ.push_back(e);
   endtask

   // Wait (bounded) for a result, compare it with the scoreboard head, and if
   // out_ready is high let the handshake edge pass.
   task automatic checkOutput(input string name);
      int   n;
      exp_t e;
      n = 0;
      while (!out_valid && n < BOUND) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!out_valid) begin
         expire({name, " out_valid"});
         return;
      end
      if (expQ.size() == 0) begin
         expire({name, " scoreboard empty"});
      end else begin
         e = expQ.pop_front();
         checkVal({name, " count"}, 32'(out_count), e.count);
         checkVal({name, " hit"}, 32'(out_hit), e.hit);
         checkVal({name, " first"}, 32'(out_first), e.first);
      end
      if (out_ready) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkResetState(input string name);
      checkVal({name, " in_ready"}, 32'(in_ready), 1);
      checkVal({name, " out_valid"}, 32'(out_valid), 0);
      checkVal({name, " busy"}, 32'(busy), 0);
      checkVal({name, " out_count"}, 32'(out_count), 0);
      checkVal({name, " out_hit"}, 32'(out_hit), 0);
      checkVal({name, " out_first"}, 32'(out_first), 0);
   endtask

   initial begin
      int   acc;
      int   cyc;
      int   sawValid;
      exp_t e;
      logic [WIDTH-1:0] rnd;

      vecs[0] = '{20'h3369A, 3, 9};
      vecs[1] = '{20'hDB6DB, 6, 3};
      vecs[2] = '{20'h00006, 0, 0};
      vecs[3] = '{20'h80000, 0, 0};
      vecs[4] = '{20'hD0000, 1, 3};
      vecs[5] = '{20'h0000D, 1, 19};
      vecs[6] = '{20'h6DB6D, 6, 4};
      vecs[7] = '{20'hFFFFF, 0, 0};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      abort     = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkResetState("reset");
      rst = 1'b0;

      // Latency: accept cycle is cycle 0, CLEAR is cycle 1, result in cycle WIDTH+2
      applyStimulus(20'h3369A, 1'b1, '{3, 9, 1}, acc);
      cyc = 1;
      while (!out_valid && cyc < BOUND) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      checkVal("latency", cyc, WIDTH + 2);
      checkOutput("latency frame");

      // Table of frames streamed back to back with out_ready held high
      fork
         begin
            for (int i = 0; i < NVEC; i++) begin
               exp_t ev;
               ev = '{vecs[i].count, vecs[i].first, (vecs[i].count != 0) ? 1 : 0};
               applyStimulus(vecs[i].data, 1'b1, ev, accCyc[i]);
            end
         end
         begin
            for (int j = 0; j < NVEC; j++) begin
               checkOutput($sformatf("vec%0d", j));
            end
         end
      join
      for (int i = 1; i < NVEC; i++) begin
         checkVal($sformatf("throughput %0d", i), accCyc[i] - accCyc[i-1], WIDTH + 3);
      end

      // Stalled consumer: result must hold and no new frame may be accepted
      out_ready = 1'b0;
      applyStimulus(20'hFFFFF, 1'b1, '{0, 0, 0}, acc);
      checkOutput("hold frame");
      repeat (10) begin
         @(posedge clk);
         #1;
         checkVal("hold out_valid", 32'(out_valid), 1);
         checkVal("hold count", 32'(out_count), 0);
         checkVal("hold first", 32'(out_first), 0);
         checkVal("hold in_ready", 32'(in_ready), 0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checkVal("hold release busy", 32'(busy), 0);
      checkVal("hold release in_ready", 32'(in_ready), 1);
      checkVal("hold release out_valid", 32'(out_valid), 0);

      // Abort at SHIFT index 10 drops the frame
      applyStimulus(20'h3369A, 1'b0, '{0, 0, 0}, acc);
      repeat (11) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      checkVal("abort in_ready", 32'(in_ready), 1);
      checkVal("abort busy", 32'(busy), 0);
      checkVal("abort out_valid", 32'(out_valid), 0);
      sawValid = 0;
      repeat (25) begin
         @(posedge clk);
         #1;
         if (out_valid) sawValid++;
      end
      checkVal("abort no result", sawValid, 0);
      applyStimulus(20'hDB6DB, 1'b1, '{6, 3, 1}, acc);
      checkOutput("after abort");

      // Abort together with out_ready in DONE behaves as a completed handshake
      out_ready = 1'b0;
      applyStimulus(20'h6DB6D, 1'b1, '{6, 4, 1}, acc);
      checkOutput("done abort frame");
      abort     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      checkVal("done abort out_valid", 32'(out_valid), 0);
      checkVal("done abort in_ready", 32'(in_ready), 1);

      // Abort in IDLE is ignored and the handshake goes ahead
      abort = 1'b1;
      applyStimulus(20'hD0000, 1'b1, '{1, 3, 1}, acc);
      abort = 1'b0;
      checkVal("idle abort busy", 32'(busy), 1);
      checkOutput("idle abort frame");

      // Reset at SHIFT index 5 loses the frame and restores reset values
      applyStimulus(20'h3369A, 1'b0, '{0, 0, 0}, acc);
      repeat (6) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkResetState("mid reset");
      applyStimulus(20'h3369A, 1'b1, '{3, 9, 1}, acc);
      checkOutput("after reset");

      // A few random frames checked against the window model
      for (int i = 0; i < 4; i++) begin
         rnd = WIDTH'($urandom);
         e   = refModel(rnd);
         applyStimulus(rnd, 1'b1, e, acc);
         checkOutput($sformatf("random%0d", i));
      end

      checkVal("scoreboard drained", expQ.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule
